// File: rtl/booth_pkg.sv
// Shared definitions for the radix-4 Booth multiplier: FSM states, digit count
// and the 3-bit multiplier window extraction.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand the window helper supports.
    localparam int unsigned MAX_WIDTH = 128;

    function automatic int unsigned digit_count(input int unsigned width);
        return width / 32'd2 + 32'd1;
    endfunction

    // The appended zero supplies b_ext[-1] so digit 0 needs no special case.
    function automatic logic [2:0] digit_window(input logic [MAX_WIDTH+1:0] b_ext,
                                                input int unsigned idx);
        logic [MAX_WIDTH+2:0] win;
        win = {b_ext, 1'b0} >> (32'd2 * idx);
        return win[2:0];
    endfunction

endpackage

// File: rtl/booth_encoder.sv
// Radix-4 Booth digit encoder: selects one of the precomputed multiplicand
// multiples and reports the sign of the selected multiple.
module booth_encoder #(
    parameter int WIDTH = 32
) (
    input  logic [2:0]     digit,
    input  logic           unsign,
    input  logic [WIDTH:0] mult_pos1,
    input  logic [WIDTH:0] mult_pos2,
    input  logic [WIDTH:0] mult_neg1,
    input  logic [WIDTH:0] mult_neg2,
    output logic [WIDTH:0] pp_out,
    output logic           s,
    output logic           p
);

    logic neg_s;

    // Multiple selection; s is the true sign, which stays correct when -2*min wraps.
    always_comb begin
        pp_out = {(WIDTH+1){1'b0}};
        neg_s  = 1'b0;
        p      = 1'b0;
        case (digit)
            3'b001, 3'b010: begin pp_out = mult_pos1; p = 1'b1; end
            3'b011:         begin pp_out = mult_pos2; p = 1'b1; end
            3'b100:         begin pp_out = mult_neg2; p = 1'b1; neg_s = 1'b1; end
            3'b101, 3'b110: begin pp_out = mult_neg1; p = 1'b1; neg_s = 1'b1; end
            default:        begin pp_out = {(WIDTH+1){1'b0}}; p = 1'b0; neg_s = 1'b0; end
        endcase
        s = neg_s ^ (~unsign & mult_pos1[WIDTH]);
    end

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier, one digit per clock.
// Optional macro BOOTH_MULT_EARLY_TERM_EN stops once the remaining digits are all zero.
module booth_mult_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_unsign,
    input  logic [WIDTH-1:0]     in_a,
    input  logic [WIDTH-1:0]     in_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out_product
);

    localparam int unsigned N  = digit_count(WIDTH);
    localparam int          CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t             state_r, state_s;
    logic [WIDTH:0]     m_pos1_r, m_pos2_r, m_neg1_r, m_neg2_r;
    logic [WIDTH+1:0]   b_ext_r;
    logic               unsign_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;

    logic [WIDTH:0]     a_ext_s;
    logic [WIDTH+1:0]   b_ext_s;
    logic               accept_s;
    logic [2:0]         digit_s;
    logic [WIDTH:0]     pp_out_s;
    logic               pp_sign_s;
    logic               pp_nz_s;
    logic [WIDTH+1:0]   pp_val_s;
    logic [2*WIDTH-1:0] pp_sext_s;
    logic [2*WIDTH-1:0] acc_next_s;
    logic               last_s;

    assign a_ext_s  = {(in_unsign ? 1'b0 : in_a[WIDTH-1]), in_a};
    assign b_ext_s  = {{2{(in_unsign ? 1'b0 : in_b[WIDTH-1])}}, in_b};
    assign accept_s = in_valid & in_ready;
    assign digit_s  = digit_window({{(MAX_WIDTH-WIDTH){1'b0}}, b_ext_r}, 32'(cnt_r));

    booth_encoder #(.WIDTH(WIDTH)) u_enc (
        .digit     (digit_s),
        .unsign    (unsign_r),
        .mult_pos1 (m_pos1_r),
        .mult_pos2 (m_pos2_r),
        .mult_neg1 (m_neg1_r),
        .mult_neg2 (m_neg2_r),
        .pp_out    (pp_out_s),
        .s         (pp_sign_s),
        .p         (pp_nz_s)
    );

    assign pp_val_s   = {pp_sign_s & (|pp_out_s), pp_out_s};
    assign pp_sext_s  = {{(WIDTH-2){pp_val_s[WIDTH+1]}}, pp_val_s};
    assign acc_next_s = pp_nz_s ? acc_r + (pp_sext_s << {cnt_r, 1'b0}) : acc_r;

`ifdef BOOTH_MULT_EARLY_TERM_EN
    logic [WIDTH+1:0] b_rest_s;
    assign b_rest_s = $signed(b_ext_r) >>> {cnt_r, 1'b1};
    assign last_s   = (cnt_r == LAST) | (b_rest_s == {(WIDTH+2){1'b0}}) | (&b_rest_s);
`else
    assign last_s   = (cnt_r == LAST);
`endif

    // Next-state and handshake decode.
    always_comb begin
        state_s  = state_r;
        in_ready = 1'b0;
        case (state_r)
            IDLE: begin
                in_ready = 1'b1;
                if (accept_s) state_s = RUN;
                else          state_s = IDLE;
            end
            RUN: begin
                in_ready = 1'b0;
                if (last_s) state_s = DONE;
                else        state_s = RUN;
            end
            DONE: begin
                in_ready = out_ready;
                if (accept_s)       state_s = RUN;
                else if (out_ready) state_s = IDLE;
                else                state_s = DONE;
            end
            default: begin
                in_ready = 1'b0;
                state_s  = IDLE;
            end
        endcase
    end

    // Operand capture, digit accumulation and product register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            m_pos1_r    <= {(WIDTH+1){1'b0}};
            m_pos2_r    <= {(WIDTH+1){1'b0}};
            m_neg1_r    <= {(WIDTH+1){1'b0}};
            m_neg2_r    <= {(WIDTH+1){1'b0}};
            b_ext_r     <= {(WIDTH+2){1'b0}};
            unsign_r    <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            acc_r       <= {(2*WIDTH){1'b0}};
            out_valid   <= 1'b0;
            out_product <= {(2*WIDTH){1'b0}};
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                m_pos1_r <= a_ext_s;
                m_pos2_r <= {a_ext_s[WIDTH-1:0], 1'b0};
                m_neg1_r <= ~a_ext_s + {{WIDTH{1'b0}}, 1'b1};
                m_neg2_r <= ~{a_ext_s[WIDTH-1:0], 1'b0} + {{WIDTH{1'b0}}, 1'b1};
                b_ext_r  <= b_ext_s;
                unsign_r <= in_unsign;
                cnt_r    <= {CW{1'b0}};
                acc_r    <= {(2*WIDTH){1'b0}};
            end else if (state_r == RUN) begin
                cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                acc_r <= acc_next_s;
            end
            if ((state_r == RUN) && last_s) begin
                out_valid   <= 1'b1;
                out_product <= acc_next_s;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
